umi_xbar: RTL and testbench
===========================

# umi_xbar

N×N combinational switch for the UMI (Universal Memory Interface) fabric. It connects N UMI input ports to N UMI output ports. Each input presents a one-hot-per-output request vector, which upstream logic decodes from the destination address. Each output has its own arbiter: it selects one requesting input and forwards that input's cmd/dstaddr/srcaddr/data with zero latency. Ready is returned to the winning input only.

## Interface
Parameters:
- N, 2, number of input and output ports (≥2)
- CW, 32, command width
- AW, 64, address width
- DW, 256, data width

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous reset, active-high (1 = reset)
- mode  in  2  arbitration mode: 00 fixed priority, 01 round-robin, 10 randomized, 11 round-robin
- mask  in  N*N  bit [j*N+i]=1 blocks input i from output j
- umi_in_request  in  N*N  bit [j*N+i]=1: input i has a valid packet for output j
- umi_in_cmd/dstaddr/srcaddr/data  in  N*CW/N*AW/N*AW/N*DW  input i occupies slice [i*W+:W]
- umi_in_ready  out  N  input i's packet accepted this cycle
- umi_out_valid  out  N  output j has a valid packet
- umi_out_cmd/dstaddr/srcaddr/data  out  N*CW/N*AW/N*AW/N*DW  output j packet fields
- umi_out_ready  in  N  output j downstream ready

## Operation
- Effective request: req[j][i] = umi_in_request[j*N+i] & ~mask[j*N+i].
- Each output j has an independent arbiter that produces a one-hot grant g[j][i] over the effective requests.
- Mode 00: the lowest input index wins.
- Mode 01/11: round-robin. The search starts at ptr[j]+1 (mod N). After a transfer, ptr[j] is set to the index of the winner.
- Mode 10: randomized. Output j keeps a 16-bit Fibonacci LFSR (taps 16,14,13,11). The rotation start is lfsr[j] mod N. The LFSR advances every cycle.
- Grant lock: when output j has umi_out_valid=1 and umi_out_ready=0, the same input stays granted next cycle, regardless of mode or new requests. The lock is released on a completed transfer, or when that input's effective request drops.
- umi_out_valid[j] = OR of g[j][*].
- Output fields = AND-OR mux of the input fields selected by g[j]. All fields are zero when nothing is granted.
- umi_in_ready[i] = OR over j of (g[j][i] & umi_out_ready[j]).
- Upstream asserts at most one request bit per input. If an input asserts several, its ready may be granted by any one output; that case is undefined but must not cause X propagation.
- Transfer on output j = umi_out_valid[j] & umi_out_ready[j].

## Timing
- Data path and ready path are fully combinational: 0-cycle latency, in the same cycle.
- Registered state: ptr[j] (resets to N-1, so input 0 wins first), lock flag and locked index (reset 0), lfsr[j] (resets to 16'hACE1 ^ j, never zero).
- All outputs are combinational. During reset and with no requests: umi_out_valid=0, umi_in_ready=0, output fields=0.
- A reset asserted mid-operation clears locks and pointers immediately. Packets held in flight by upstream remain the sender's responsibility.
- Simultaneous requests from several inputs to one output give exactly one grant per cycle. Different outputs are granted in parallel with no interaction.
- A mode change takes effect in the next unlocked arbitration.

## Configuration
- UMI_XBAR_RANDOM_EN defined: mode 10 uses the per-output LFSR as described.
- Undefined: no LFSR is built and mode 10 behaves identically to round-robin (01).

## Test plan
- Reset held, arbitrary requests -> umi_out_valid=0, umi_in_ready=0. Release reset with input 2 requesting output 1 and umi_out_ready[1]=1 -> out_valid[1]=1, out_dstaddr[1]=in_dstaddr[2], in_ready[2]=1 in the same cycle.
- N=4, mode 00, inputs 1 and 3 both request output 0, ready=1 -> input 1 is served every cycle and input 3 is starved.
- Mode 01, all four inputs request output 2 continuously, ready=1 -> grant sequence 0,1,2,3,0.
- Backpressure: input 3 granted output 0 with ready=0 for 5 cycles while input 0 also requests -> grant stays on input 3 and data is stable. When ready=1, input 3 is accepted, then input 0 is granted.
- mask[0*4+1]=1, input 1 requests output 0 -> no valid on output 0 and in_ready[1]=0. Clearing the mask bit grants it.
- Mode 10 with UMI_XBAR_RANDOM_EN, four inputs saturating output 0 for 4000 cycles -> each input receives between 800 and 1200 grants and none is starved. Without the macro, the grant sequence matches the round-robin scenario.

Source files
------------

// File: rtl/umi_xbar.sv
// umi_xbar: N x N combinational UMI crossbar with one arbiter per output.
//
// Each output j picks one input among its effective requests
// (umi_in_request & ~mask) and forwards that input's cmd/dstaddr/srcaddr/data
// with zero latency. Ready returns only to the winning input.
//
// Ports:
//   clk, nreset          clock, asynchronous active-high reset
//   mode                 00 fixed priority, 01/11 round-robin, 10 randomized
//   mask                 bit [j*N+i] blocks input i from output j
//   umi_in_request       bit [j*N+i] = input i has a packet for output j
//   umi_in_cmd/dstaddr/srcaddr/data   input i at slice [i*W +: W]
//   umi_in_ready         input i accepted this cycle
//   umi_out_valid        output j carries a packet
//   umi_out_cmd/dstaddr/srcaddr/data  output j at slice [j*W +: W]
//   umi_out_ready        output j downstream ready
//
// Build option: define UMI_XBAR_RANDOM_EN to build a per-output 16-bit LFSR
// that randomizes the arbitration start in mode 10. Without it, mode 10
// behaves exactly like round-robin.

module umi_xbar #(
  parameter int unsigned N  = 2,
  parameter int unsigned CW = 32,
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 256
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [1:0]        mode,
  input  logic [N*N-1:0]    mask,
  input  logic [N*N-1:0]    umi_in_request,
  input  logic [N*CW-1:0]   umi_in_cmd,
  input  logic [N*AW-1:0]   umi_in_dstaddr,
  input  logic [N*AW-1:0]   umi_in_srcaddr,
  input  logic [N*DW-1:0]   umi_in_data,
  output logic [N-1:0]      umi_in_ready,
  output logic [N-1:0]      umi_out_valid,
  output logic [N*CW-1:0]   umi_out_cmd,
  output logic [N*AW-1:0]   umi_out_dstaddr,
  output logic [N*AW-1:0]   umi_out_srcaddr,
  output logic [N*DW-1:0]   umi_out_data,
  input  logic [N-1:0]      umi_out_ready
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req      [N];
  logic [N-1:0]    grant    [N];
  logic [IW-1:0]   win_idx  [N];
  logic [N-1:0]    found;
  int unsigned     start_idx [N];
  int unsigned     cand;

  logic [IW-1:0]   ptr_q      [N];
  logic [IW-1:0]   ptr_d      [N];
  logic [IW-1:0]   lock_idx_q [N];
  logic [IW-1:0]   lock_idx_d [N];
  logic [N-1:0]    lock_q;
  logic [N-1:0]    lock_d;

`ifdef UMI_XBAR_RANDOM_EN
  logic [15:0]     lfsr_q [N];
  logic [15:0]     lfsr_d [N];
`endif

  // Per-output arbitration: locked input first, else rotating search from start_idx.
  always_comb begin
    cand  = 0;
    found = '0;
    for (int j = 0; j < N; j++) begin
      grant[j]     = '0;
      win_idx[j]   = '0;
      start_idx[j] = 0;
      for (int i = 0; i < N; i++) begin
        req[j][i] = umi_in_request[j*N+i] & ~mask[j*N+i];
      end
      if (lock_q[j] && req[j][lock_idx_q[j]]) begin
        grant[j][lock_idx_q[j]] = 1'b1;
        win_idx[j]              = lock_idx_q[j];
        found[j]                = 1'b1;
      end else begin
        case (mode)
          2'b00:   start_idx[j] = 0;
`ifdef UMI_XBAR_RANDOM_EN
          2'b10:   start_idx[j] = 32'(lfsr_q[j] % 16'(N));
`endif
          default: start_idx[j] = (32'(ptr_q[j]) + 32'd1) % N;
        endcase
        for (int k = 0; k < N; k++) begin
          cand = start_idx[j] + 32'(k);
          if (cand >= N) cand = cand - N;
          if (!found[j] && req[j][cand]) begin
            found[j]       = 1'b1;
            grant[j][cand] = 1'b1;
            win_idx[j]     = IW'(cand);
          end
        end
      end
      // Nothing is granted while reset is asserted.
      if (nreset) grant[j] = '0;
    end
  end

  // AND-OR output mux and ready return.
  always_comb begin
    umi_out_valid   = '0;
    umi_out_cmd     = '0;
    umi_out_dstaddr = '0;
    umi_out_srcaddr = '0;
    umi_out_data    = '0;
    umi_in_ready    = '0;
    for (int j = 0; j < N; j++) begin
      umi_out_valid[j] = |grant[j];
      for (int i = 0; i < N; i++) begin
        umi_out_cmd[j*CW+:CW]     = umi_out_cmd[j*CW+:CW]     | ({CW{grant[j][i]}} & umi_in_cmd[i*CW+:CW]);
        umi_out_dstaddr[j*AW+:AW] = umi_out_dstaddr[j*AW+:AW] | ({AW{grant[j][i]}} & umi_in_dstaddr[i*AW+:AW]);
        umi_out_srcaddr[j*AW+:AW] = umi_out_srcaddr[j*AW+:AW] | ({AW{grant[j][i]}} & umi_in_srcaddr[i*AW+:AW]);
        umi_out_data[j*DW+:DW]    = umi_out_data[j*DW+:DW]    | ({DW{grant[j][i]}} & umi_in_data[i*DW+:DW]);
        umi_in_ready[i]           = umi_in_ready[i] | (grant[j][i] & umi_out_ready[j]);
      end
    end
  end

  // Pointer/lock update: a stalled grant locks, a transfer moves the pointer.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      ptr_d[j]      = ptr_q[j];
      lock_idx_d[j] = lock_idx_q[j];
      lock_d[j]     = 1'b0;
      if (umi_out_valid[j] && umi_out_ready[j]) begin
        ptr_d[j] = win_idx[j];
      end else if (umi_out_valid[j]) begin
        lock_d[j]     = 1'b1;
        lock_idx_d[j] = win_idx[j];
      end
`ifdef UMI_XBAR_RANDOM_EN
      // Fibonacci LFSR, taps 16,14,13,11.
      lfsr_d[j] = {lfsr_q[j][14:0], lfsr_q[j][15] ^ lfsr_q[j][13] ^ lfsr_q[j][12] ^ lfsr_q[j][10]};
`endif
    end
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      for (int j = 0; j < N; j++) begin
        ptr_q[j]      <= IW'(N - 1);
        lock_idx_q[j] <= '0;
`ifdef UMI_XBAR_RANDOM_EN
        lfsr_q[j]     <= 16'hACE1 ^ 16'(j);
`endif
      end
      lock_q <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        ptr_q[j]      <= ptr_d[j];
        lock_idx_q[j] <= lock_idx_d[j];
`ifdef UMI_XBAR_RANDOM_EN
        lfsr_q[j]     <= lfsr_d[j];
`endif
      end
      lock_q <= lock_d;
    end
  end

endmodule

// File: tb/tb_umi_xbar.sv
// Scoreboard bench for umi_xbar (N=4): the driver pushes the expected
// response of each cycle, a monitor pops and compares on the falling edge.

module tb_umi_xbar;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;

  logic              clk = 1'b0;
  logic              nreset;
  logic [1:0]        mode;
  logic [N*N-1:0]    mask;
  logic [N*N-1:0]    umi_in_request;
  logic [N*CW-1:0]   umi_in_cmd;
  logic [N*AW-1:0]   umi_in_dstaddr;
  logic [N*AW-1:0]   umi_in_srcaddr;
  logic [N*DW-1:0]   umi_in_data;
  logic [N-1:0]      umi_in_ready;
  logic [N-1:0]      umi_out_valid;
  logic [N*CW-1:0]   umi_out_cmd;
  logic [N*AW-1:0]   umi_out_dstaddr;
  logic [N*AW-1:0]   umi_out_srcaddr;
  logic [N*DW-1:0]   umi_out_data;
  logic [N-1:0]      umi_out_ready;

  umi_xbar #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .mode            (mode),
    .mask            (mask),
    .umi_in_request  (umi_in_request),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [N-1:0]      valid;
    logic [N-1:0]      rdy;
    logic [N*CW-1:0]   cmd;
    logic [N*AW-1:0]   dst;
    logic [N*AW-1:0]   src;
    logic [N*DW-1:0]   data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: compare the DUT outputs against the expectation of this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".valid"}, 256'(umi_out_valid), 256'(e.valid));
      chk({e.name, ".in_ready"}, 256'(umi_in_ready), 256'(e.rdy));
      for (int j = 0; j < N; j++) begin
        chk($sformatf("%s.cmd%0d", e.name, j), 256'(umi_out_cmd[j*CW+:CW]), 256'(e.cmd[j*CW+:CW]));
        chk($sformatf("%s.dst%0d", e.name, j), 256'(umi_out_dstaddr[j*AW+:AW]), 256'(e.dst[j*AW+:AW]));
        chk($sformatf("%s.src%0d", e.name, j), 256'(umi_out_srcaddr[j*AW+:AW]), 256'(e.src[j*AW+:AW]));
        chk($sformatf("%s.data%0d", e.name, j), umi_out_data[j*DW+:DW], e.data[j*DW+:DW]);
      end
    end
  end

  // Drive one cycle and push the hand-derived winner of each output (-1 = none).
  task automatic cycle(input string nm, input logic rst, input logic [1:0] md,
                       input logic [15:0] rq, input logic [15:0] mk, input logic [3:0] rdy,
                       input int s0, input int s1, input int s2, input int s3);
    exp_t x;
    int   s[N];
    s = '{s0, s1, s2, s3};
    @(posedge clk);
    #1;
    nreset         = rst;
    mode           = md;
    umi_in_request = rq;
    mask           = mk;
    umi_out_ready  = rdy;
    x.name  = nm;
    x.valid = '0;
    x.rdy   = '0;
    x.cmd   = '0;
    x.dst   = '0;
    x.src   = '0;
    x.data  = '0;
    for (int j = 0; j < N; j++) begin
      if (s[j] >= 0) begin
        x.valid[j]          = 1'b1;
        x.cmd[j*CW+:CW]     = umi_in_cmd[s[j]*CW+:CW];
        x.dst[j*AW+:AW]     = umi_in_dstaddr[s[j]*AW+:AW];
        x.src[j*AW+:AW]     = umi_in_srcaddr[s[j]*AW+:AW];
        x.data[j*DW+:DW]    = umi_in_data[s[j]*DW+:DW];
        if (rdy[j]) x.rdy[s[j]] = 1'b1;
      end
    end
    exp_q.push_back(x);
  endtask

  initial begin
    nreset         = 1'b1;
    mode           = 2'b00;
    mask           = '0;
    umi_in_request = '0;
    umi_out_ready  = '0;
    for (int i = 0; i < N; i++) begin
      umi_in_cmd[i*CW+:CW]     = 32'hC000_0000 + 32'(i);
      umi_in_dstaddr[i*AW+:AW] = 64'hDD00_0000_0000_0000 + 64'(i) * 64'h111;
      umi_in_srcaddr[i*AW+:AW] = 64'h5500_0000_0000_0000 + 64'(i) * 64'h2_0000;
      umi_in_data[i*DW+:DW]    = {8{32'hA5A5_0000 + 32'(i)}};
    end

    // Reset held with requests: nothing passes.
    cycle("rst_hold", 1'b1, 2'b00, 16'h0041, 16'h0, 4'hF, -1, -1, -1, -1);
    // Released: input 2 -> output 1 in the same cycle.
    cycle("first",    1'b0, 2'b00, 16'h0040, 16'h0, 4'hF, -1,  2, -1, -1);
    // Fixed priority: input 1 beats input 3 every cycle.
    for (int c = 0; c < 3; c++)
      cycle($sformatf("fixed%0d", c), 1'b0, 2'b00, 16'h000A, 16'h0, 4'hF, 1, -1, -1, -1);
    // Round-robin on output 2 from the reset pointer: 0,1,2,3,0.
    begin
      int rr_seq[5];
      rr_seq = '{0, 1, 2, 3, 0};
      for (int c = 0; c < 5; c++)
        cycle($sformatf("rr%0d", c), 1'b0, 2'b01, 16'h0F00, 16'h0, 4'hF, -1, -1, rr_seq[c], -1);
    end
    // Backpressure: input 3 locked on output 0 for 5 stalled cycles, fixed priority would pick 0.
    cycle("bp0", 1'b0, 2'b01, 16'h0008, 16'h0, 4'hE, 3, -1, -1, -1);
    for (int c = 1; c < 5; c++)
      cycle($sformatf("bp%0d", c), 1'b0, 2'b00, 16'h0009, 16'h0, 4'hE, 3, -1, -1, -1);
    cycle("bp_xfer", 1'b0, 2'b00, 16'h0009, 16'h0, 4'hF, 3, -1, -1, -1);
    cycle("bp_next", 1'b0, 2'b00, 16'h0001, 16'h0, 4'hF, 0, -1, -1, -1);
    // Lock released when the locked input drops its request.
    cycle("lk_set",  1'b0, 2'b00, 16'h4000, 16'h0, 4'h7, -1, -1, -1, 2);
    cycle("lk_drop", 1'b0, 2'b00, 16'h2000, 16'h0, 4'h7, -1, -1, -1, 1);
    cycle("idle",    1'b0, 2'b00, 16'h0000, 16'h0, 4'hF, -1, -1, -1, -1);
    // Mask blocks input 1 from output 0; clearing it grants.
    cycle("masked",   1'b0, 2'b00, 16'h0002, 16'h0002, 4'hF, -1, -1, -1, -1);
    cycle("unmasked", 1'b0, 2'b00, 16'h0002, 16'h0000, 4'hF,  1, -1, -1, -1);
    // All four outputs in parallel, ready only on outputs 1 and 3.
    cycle("parallel", 1'b0, 2'b00, 16'h4812, 16'h0, 4'hA, 1, 0, 3, 2);
    cycle("idle2",    1'b0, 2'b00, 16'h0000, 16'h0, 4'hF, -1, -1, -1, -1);

`ifdef UMI_XBAR_RANDOM_EN
    // Randomized arbitration on output 0: roughly even share, nobody starved.
    begin
      int cnt[N];
      int bad;
      bad = 0;
      cnt = '{0, 0, 0, 0};
      for (int c = 0; c < 4000; c++) begin
        @(posedge clk);
        #1;
        mode           = 2'b10;
        umi_in_request = 16'h000F;
        mask           = '0;
        umi_out_ready  = 4'hF;
        @(negedge clk);
        if (umi_out_valid[0] && $countones(umi_in_ready) == 1) begin
          for (int i = 0; i < N; i++) if (umi_in_ready[i]) cnt[i]++;
        end else begin
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_onehot: got %0d bad cycles expected 0", bad);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (cnt[i] < 800 || cnt[i] > 1200) begin
          errors++;
          $display("FAIL rand_share%0d: got %0d grants expected 800..1200", i, cnt[i]);
        end
      end
    end
`else
    // Without the LFSR, mode 10 continues round-robin on output 2 (pointer at 0).
    begin
      int rnd_seq[4];
      rnd_seq = '{1, 2, 3, 0};
      for (int c = 0; c < 4; c++)
        cycle($sformatf("m10_%0d", c), 1'b0, 2'b10, 16'h0F00, 16'h0, 4'hF, -1, -1, rnd_seq[c], -1);
    end
`endif
    // Mode 11 is round-robin as well.
    cycle("m11", 1'b0, 2'b11, 16'h0F00, 16'h0, 4'hF, -1, -1, 1, -1);

    // Let the monitor drain, bounded.
    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
